mark_result_store: RTL and testbench
====================================

Name: mark_result_store

Overview:
- Parametrised result collector between mark_counter_assembly and the host interface.
- Accepts candidate rulers (full mark vectors) as the search emits them. Keeps up to DEPTH rulers of the shortest length seen so far, and exports that length as a pruning bound.
- On search completion, streams the stored rulers out with a valid/ready handshake.
- Replaces the fixed 5-result, 6-mark results array with generic width, depth and a readout protocol.

Parameters:
- NUMPOSITIONS, 5, index of the last mark; a ruler has NUMPOSITIONS+1 marks, m[0]..m[NUMPOSITIONS].
- VALUEBITS, 9, width of one mark value.
- DEPTH, 8, maximum number of equal-length rulers retained (≥1).
- CNTBITS, 6, width of the count output; must hold DEPTH.

Ports:
- clock  in  1  sole clock, all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- cand_valid  in  1  candidate ruler present.
- cand_ready  out  1  store can accept a candidate this cycle.
- cand_marks  in  (NUMPOSITIONS+1)*VALUEBITS  packed ruler, m[0] in the MSBs; length is m[NUMPOSITIONS].
- search_done  in  1  one-cycle pulse: search finished, begin readout.
- best_len  out  VALUEBITS  shortest length stored; all-ones when none.
- num_results  out  CNTBITS  rulers currently stored.
- overflow  out  1  sticky: an equal-length ruler was dropped because the store was full.
- out_valid  out  1  out_marks holds a stored ruler.
- out_ready  in  1  consumer accepts out_marks.
- out_marks  out  (NUMPOSITIONS+1)*VALUEBITS  ruler being read out.
- out_last  out  1  qualifies the final ruler of the readout.
- done  out  1  readout complete; held until reset.

Behaviour:
- Reset values (applied on a clock edge with reset=1, in any state): state COLLECT, best_len all-ones, num_results 0, overflow 0, out_valid 0, out_last 0, done 0, cand_ready 1, out_marks 0. Storage contents are don't-care.
- States: COLLECT, DRAIN, DONE.
- COLLECT:
  - cand_ready=1. A handshake is cand_valid & cand_ready; one candidate per cycle; updates are visible on the next cycle.
  - L < best_len: slot0 <= candidate; num_results <= 1; best_len <= L; overflow <= 0.
  - L == best_len and num_results < DEPTH: slot[num_results] <= candidate; num_results increments.
  - L == best_len and num_results == DEPTH: candidate dropped; overflow <= 1.
  - L > best_len: candidate dropped, no state change.
  - A candidate with L equal to all-ones is treated as L < best_len only while num_results==0 (degenerate case; storage still correct).
- Leaving COLLECT:
  - search_done in COLLECT moves to DRAIN next cycle, or to DONE if num_results==0 (no out_valid pulse at all).
  - A candidate accepted in the same cycle as search_done is stored before the transition.
  - cand_ready=0 outside COLLECT; candidates are ignored.
  - search_done outside COLLECT is ignored.
- DRAIN:
  - Emits slots 0..num_results-1 in insertion order via a registered read pointer.
  - out_valid=1 with out_marks=slot[ptr]; out_last=1 when ptr==num_results-1.
  - out_valid & out_ready advances ptr. The transfer with out_last moves to DONE; out_valid drops the next cycle.
  - out_marks and out_last stay stable while out_valid & !out_ready.
  - First out_valid appears one cycle after search_done.
- DONE: done=1; best_len, num_results and overflow hold.
- best_len feeds back to the counter as a prune bound: the counter may skip any L > best_len.
- Reset mid-DRAIN aborts the readout; the next cycle is COLLECT with an empty store.

Decomposition:
- Shared definitions package / include (extends definitions.v): NUMPOSITIONS, VALUEBITS, RULERBITS=(NUMPOSITIONS+1)*VALUEBITS, state encodings, ALLONES length constant.
- One natural sub-module: mark_result_ram, a DEPTH x RULERBITS register file (synchronous write port, combinational read port), addressed by write count and read pointer.

Test Plan:
- Ruler 0-1-4-10-12-17 then 0-1-4-10-15-17, then search_done, out_ready=1 → two transfers in order, out_last on the second, num_results=2, best_len=17, done=1.
- Candidates with lengths 25, 20, 17 (distinct rulers) → num_results=1 and best_len=17 after the third; readout yields only the 17-length ruler.
- DEPTH=2; three length-17 rulers → num_results=2, overflow=1; the third is never read out.
- search_done with nothing stored → done=1 next cycle, out_valid never asserted, best_len all-ones.
- Drain with out_ready toggling 0,1,0,0,1 → out_marks stable while stalled, exactly num_results transfers.
- Reset asserted in DRAIN after the first transfer → next cycle num_results=0, out_valid=0, cand_ready=1, overflow=0.

Source files
------------

// File: rtl/mark_result_store_pkg.sv
// mark_result_store_pkg: shared defaults, state encoding and sizing helpers for the result store
// Contents:
//   DEF_*        default parameter values for mark_result_store
//   state_e      COLLECT / DRAIN / DONE controller states
//   ruler_bits   packed width of a full ruler (NUMPOSITIONS+1 marks)
//   addr_bits    address width for a DEPTH-entry store (at least 1)
package mark_result_store_pkg;
    localparam int DEF_NUMPOSITIONS = 5;
    localparam int DEF_VALUEBITS    = 9;
    localparam int DEF_DEPTH        = 8;
    localparam int DEF_CNTBITS      = 6;

    typedef enum logic [1:0] {
        ST_COLLECT,
        ST_DRAIN,
        ST_DONE
    } state_e;

    function automatic int ruler_bits(input int num_positions, input int value_bits);
        return (num_positions + 1) * value_bits;
    endfunction

    function automatic int addr_bits(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction
endpackage

// File: rtl/mark_result_ram.sv
// mark_result_ram: DEPTH x WIDTH register file, synchronous write, combinational read
// Ports:
//   clk_i    clock, write on rising edge
//   we_i     write enable
//   waddr_i  write address
//   wdata_i  write data
//   raddr_i  read address
//   rdata_o  read data (combinational)
module mark_result_ram #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 54,
    parameter int AW    = 3
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/mark_result_store.sv
// mark_result_store: keeps the shortest candidate rulers, exports a prune bound, streams them out on completion
// Ports:
//   clock, reset              rising-edge clock, synchronous active-high reset
//   cand_valid/ready/marks    candidate ruler input (m[0] in MSBs, length = m[NUMPOSITIONS] in LSBs)
//   search_done               one-cycle pulse starting readout
//   best_len                  shortest stored length, all-ones when empty
//   num_results               rulers currently stored
//   overflow                  sticky: equal-length ruler dropped because store was full
//   out_valid/ready/marks     readout stream, out_last marks the final ruler
//   done                      readout complete, held until reset
module mark_result_store
    import mark_result_store_pkg::*;
#(
    parameter int NUMPOSITIONS = DEF_NUMPOSITIONS,
    parameter int VALUEBITS    = DEF_VALUEBITS,
    parameter int DEPTH        = DEF_DEPTH,
    parameter int CNTBITS      = DEF_CNTBITS
) (
    input  logic                                      clock,
    input  logic                                      reset,
    input  logic                                      cand_valid,
    output logic                                      cand_ready,
    input  logic [(NUMPOSITIONS+1)*VALUEBITS-1:0]     cand_marks,
    input  logic                                      search_done,
    output logic [VALUEBITS-1:0]                      best_len,
    output logic [CNTBITS-1:0]                        num_results,
    output logic                                      overflow,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [(NUMPOSITIONS+1)*VALUEBITS-1:0]     out_marks,
    output logic                                      out_last,
    output logic                                      done
);
    localparam int RB = ruler_bits(NUMPOSITIONS, VALUEBITS);
    localparam int AW = addr_bits(DEPTH);

    state_e               state_q, state_d;
    logic [VALUEBITS-1:0] best_len_q, best_len_d;
    logic [CNTBITS-1:0]   num_q, num_d;
    logic [CNTBITS-1:0]   ptr_q, ptr_d;
    logic                 overflow_q, overflow_d;
    logic                 out_valid_q, out_valid_d;
    logic                 out_last_q, out_last_d;
    logic                 done_q, done_d;
    logic                 cand_ready_q, cand_ready_d;

    logic [VALUEBITS-1:0] cand_len;
    logic                 take, shorter, equal, wr_en;
    logic [AW-1:0]        wr_addr;
    logic [RB-1:0]        rd_data;

    assign cand_len = cand_marks[VALUEBITS-1:0];
    assign take     = cand_valid & (state_q == ST_COLLECT);
    // An empty store accepts anything, including an all-ones length.
    assign shorter  = (cand_len < best_len_q) | (num_q == '0);
    assign equal    = !shorter & (cand_len == best_len_q);
    assign wr_en    = take & (shorter | (equal & (num_q < CNTBITS'(DEPTH))));
    assign wr_addr  = shorter ? '0 : num_q[AW-1:0];

    mark_result_ram #(
        .DEPTH (DEPTH),
        .WIDTH (RB),
        .AW    (AW)
    ) u_ram (
        .clk_i   (clock),
        .we_i    (wr_en),
        .waddr_i (wr_addr),
        .wdata_i (cand_marks),
        .raddr_i (ptr_q[AW-1:0]),
        .rdata_o (rd_data)
    );

    always_comb begin
        state_d      = state_q;
        best_len_d   = best_len_q;
        num_d        = num_q;
        ptr_d        = ptr_q;
        overflow_d   = overflow_q;
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        done_d       = done_q;
        cand_ready_d = cand_ready_q;
        if (take) begin
            if (shorter) begin
                num_d      = CNTBITS'(1);
                best_len_d = cand_len;
                overflow_d = 1'b0;
            end else if (equal) begin
                if (num_q < CNTBITS'(DEPTH)) num_d = num_q + CNTBITS'(1);
                else overflow_d = 1'b1;
            end
        end
        case (state_q)
            ST_COLLECT: begin
                // num_d already includes a candidate taken alongside search_done.
                if (search_done) begin
                    ptr_d        = '0;
                    cand_ready_d = 1'b0;
                    if (num_d == '0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d     = ST_DRAIN;
                        out_valid_d = 1'b1;
                        out_last_d  = (num_d == CNTBITS'(1));
                    end
                end
            end
            ST_DRAIN: begin
                if (out_ready) begin
                    if (out_last_q) begin
                        state_d     = ST_DONE;
                        done_d      = 1'b1;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                    end else begin
                        ptr_d      = ptr_q + CNTBITS'(1);
                        out_last_d = (ptr_q + CNTBITS'(2) == num_q);
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_COLLECT;
            best_len_q   <= '1;
            num_q        <= '0;
            ptr_q        <= '0;
            overflow_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            done_q       <= 1'b0;
            cand_ready_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            best_len_q   <= best_len_d;
            num_q        <= num_d;
            ptr_q        <= ptr_d;
            overflow_q   <= overflow_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            done_q       <= done_d;
            cand_ready_q <= cand_ready_d;
        end
    end

    assign cand_ready  = cand_ready_q;
    assign best_len    = best_len_q;
    assign num_results = num_q;
    assign overflow    = overflow_q;
    assign out_valid   = out_valid_q;
    assign out_last    = out_last_q;
    assign done        = done_q;
    // The read pointer is registered, so gating keeps the readout port quiet outside DRAIN.
    assign out_marks   = out_valid_q ? rd_data : '0;
endmodule

// File: tb/tb_mark_result_store.sv
// tb_mark_result_store: directed bench for mark_result_store (DEPTH=8 instance plus a DEPTH=2 instance)
module tb_mark_result_store;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cand_valid = 1'b0;
    logic [53:0] cand_marks = '0;
    logic        search_done = 1'b0;
    logic        out_ready = 1'b0;

    logic        cand_ready, overflow, out_valid, out_last, done;
    logic [8:0]  best_len;
    logic [5:0]  num_results;
    logic [53:0] out_marks;

    logic        b_cand_ready, b_overflow, b_out_valid, b_out_last, b_done;
    logic [8:0]  b_best_len;
    logic [5:0]  b_num_results;
    logic [53:0] b_out_marks;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    mark_result_store dut (
        .clock(clock), .reset(reset),
        .cand_valid(cand_valid), .cand_ready(cand_ready), .cand_marks(cand_marks),
        .search_done(search_done), .best_len(best_len), .num_results(num_results),
        .overflow(overflow), .out_valid(out_valid), .out_ready(out_ready),
        .out_marks(out_marks), .out_last(out_last), .done(done)
    );

    mark_result_store #(.DEPTH(2)) dut2 (
        .clock(clock), .reset(reset),
        .cand_valid(cand_valid), .cand_ready(b_cand_ready), .cand_marks(cand_marks),
        .search_done(search_done), .best_len(b_best_len), .num_results(b_num_results),
        .overflow(b_overflow), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_marks(b_out_marks), .out_last(b_out_last), .done(b_done)
    );

    function automatic logic [53:0] ruler(input int a, b, c, d, e, f);
        return {9'(a), 9'(b), 9'(c), 9'(d), 9'(e), 9'(f)};
    endfunction

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1; cand_valid = 1'b0; search_done = 1'b0; out_ready = 1'b0;
        step;
        reset = 1'b0;
    endtask

    task automatic send(input logic [53:0] m);
        cand_valid = 1'b1; cand_marks = m;
        step;
        cand_valid = 1'b0;
    endtask

    task automatic pulse_done;
        search_done = 1'b1;
        step;
        search_done = 1'b0;
    endtask

    task automatic test_reset;
        step;
        do_reset;
        n_cmp++; if (best_len !== 9'h1ff) begin n_bad++; $display("FAIL reset_best_len got %h want 1ff", best_len); end
        n_cmp++; if (num_results !== 6'd0) begin n_bad++; $display("FAIL reset_num got %0d want 0", num_results); end
        n_cmp++; if ({overflow, out_valid, out_last, done, cand_ready} !== 5'b00001) begin n_bad++; $display("FAIL reset_flags got %b want 00001", {overflow, out_valid, out_last, done, cand_ready}); end
        n_cmp++; if (out_marks !== 54'd0) begin n_bad++; $display("FAIL reset_out_marks got %h want 0", out_marks); end
    endtask

    task automatic test_basic;
        logic [53:0] r1, r2;
        r1 = ruler(0, 1, 4, 10, 12, 17);
        r2 = ruler(0, 1, 4, 10, 15, 17);
        do_reset;
        send(r1);
        send(r2);
        n_cmp++; if (num_results !== 6'd2) begin n_bad++; $display("FAIL basic_num got %0d want 2", num_results); end
        n_cmp++; if (best_len !== 9'd17) begin n_bad++; $display("FAIL basic_best got %0d want 17", best_len); end
        out_ready = 1'b1;
        pulse_done;
        n_cmp++; if ({out_valid, out_last, cand_ready} !== 3'b100) begin n_bad++; $display("FAIL basic_first_flags got %b want 100", {out_valid, out_last, cand_ready}); end
        n_cmp++; if (out_marks !== r1) begin n_bad++; $display("FAIL basic_first got %h want %h", out_marks, r1); end
        step;
        n_cmp++; if ({out_valid, out_last} !== 2'b11) begin n_bad++; $display("FAIL basic_second_flags got %b want 11", {out_valid, out_last}); end
        n_cmp++; if (out_marks !== r2) begin n_bad++; $display("FAIL basic_second got %h want %h", out_marks, r2); end
        step;
        n_cmp++; if ({out_valid, done} !== 2'b01) begin n_bad++; $display("FAIL basic_done got %b want 01", {out_valid, done}); end
        send(ruler(0, 1, 2, 3, 4, 5));
        n_cmp++; if ({num_results, best_len, done} !== {6'd2, 9'd17, 1'b1}) begin n_bad++; $display("FAIL basic_hold got num=%0d best=%0d done=%b want 2 17 1", num_results, best_len, done); end
        out_ready = 1'b0;
    endtask

    task automatic test_shorter;
        logic [53:0] r3;
        r3 = ruler(0, 1, 8, 11, 13, 17);
        do_reset;
        send(ruler(0, 1, 3, 7, 12, 25));
        n_cmp++; if ({num_results, best_len} !== {6'd1, 9'd25}) begin n_bad++; $display("FAIL short_first got num=%0d best=%0d want 1 25", num_results, best_len); end
        send(ruler(0, 2, 5, 11, 13, 20));
        send(ruler(0, 3, 4, 9, 14, 30));
        send(r3);
        n_cmp++; if ({num_results, best_len} !== {6'd1, 9'd17}) begin n_bad++; $display("FAIL short_final got num=%0d best=%0d want 1 17", num_results, best_len); end
        out_ready = 1'b1;
        pulse_done;
        n_cmp++; if ({out_valid, out_last} !== 2'b11) begin n_bad++; $display("FAIL short_flags got %b want 11", {out_valid, out_last}); end
        n_cmp++; if (out_marks !== r3) begin n_bad++; $display("FAIL short_marks got %h want %h", out_marks, r3); end
        step;
        n_cmp++; if ({out_valid, done} !== 2'b01) begin n_bad++; $display("FAIL short_done got %b want 01", {out_valid, done}); end
        out_ready = 1'b0;
    endtask

    task automatic test_overflow;
        logic [53:0] a, b;
        a = ruler(0, 1, 4, 10, 12, 17);
        b = ruler(0, 1, 4, 10, 15, 17);
        do_reset;
        send(a);
        send(b);
        n_cmp++; if (b_overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_before got %b want 0", b_overflow); end
        send(ruler(0, 2, 7, 13, 16, 17));
        n_cmp++; if ({b_num_results, b_overflow} !== {6'd2, 1'b1}) begin n_bad++; $display("FAIL ovf_small got num=%0d ovf=%b want 2 1", b_num_results, b_overflow); end
        n_cmp++; if ({num_results, overflow} !== {6'd3, 1'b0}) begin n_bad++; $display("FAIL ovf_big got num=%0d ovf=%b want 3 0", num_results, overflow); end
        out_ready = 1'b1;
        pulse_done;
        n_cmp++; if ({b_out_valid, b_out_last, b_out_marks} !== {2'b10, a}) begin n_bad++; $display("FAIL ovf_rd0 got %b %h want 10 %h", {b_out_valid, b_out_last}, b_out_marks, a); end
        step;
        n_cmp++; if ({b_out_valid, b_out_last, b_out_marks} !== {2'b11, b}) begin n_bad++; $display("FAIL ovf_rd1 got %b %h want 11 %h", {b_out_valid, b_out_last}, b_out_marks, b); end
        step;
        n_cmp++; if ({b_out_valid, b_done, b_overflow} !== 3'b011) begin n_bad++; $display("FAIL ovf_done got %b want 011", {b_out_valid, b_done, b_overflow}); end
        out_ready = 1'b0;
    endtask

    task automatic test_overflow_clear;
        do_reset;
        send(ruler(0, 1, 4, 10, 12, 17));
        send(ruler(0, 1, 4, 10, 15, 17));
        send(ruler(0, 2, 7, 13, 16, 17));
        send(ruler(0, 1, 4, 9, 11, 14));
        n_cmp++; if ({b_num_results, b_best_len, b_overflow} !== {6'd1, 9'd14, 1'b0}) begin n_bad++; $display("FAIL ovf_clear got num=%0d best=%0d ovf=%b want 1 14 0", b_num_results, b_best_len, b_overflow); end
    endtask

    task automatic test_empty;
        int seen;
        do_reset;
        out_ready = 1'b1;
        pulse_done;
        seen = 0;
        n_cmp++; if ({done, cand_ready, best_len} !== {2'b10, 9'h1ff}) begin n_bad++; $display("FAIL empty_done got done=%b rdy=%b best=%h want 1 0 1ff", done, cand_ready, best_len); end
        for (int i = 0; i < 4; i++) begin
            if (out_valid) seen++;
            step;
        end
        n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL empty_valid got %0d cycles want 0", seen); end
        out_ready = 1'b0;
    endtask

    task automatic test_stall;
        logic [53:0] exp_r [3];
        logic        pat [5];
        int          k;
        logic        fin;
        exp_r[0] = ruler(0, 1, 4, 10, 12, 17);
        exp_r[1] = ruler(0, 1, 4, 10, 15, 17);
        exp_r[2] = ruler(0, 2, 7, 13, 16, 17);
        pat = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        do_reset;
        send(exp_r[0]);
        send(exp_r[1]);
        send(exp_r[2]);
        out_ready = 1'b0;
        pulse_done;
        k = 0;
        fin = 1'b0;
        for (int i = 0; i < 20 && !fin; i++) begin
            if (done) fin = 1'b1;
            else begin
                out_ready = (i < 5) ? pat[i] : 1'b1;
                n_cmp++;
                if (!out_valid || k > 2 || out_marks !== exp_r[k > 2 ? 2 : k] || out_last !== (k == 2)) begin
                    n_bad++;
                    $display("FAIL stall_beat%0d got v=%b l=%b %h want ruler %0d", i, out_valid, out_last, out_marks, k);
                end
                if (out_valid && out_ready) k++;
                step;
            end
        end
        n_cmp++; if ({fin, k} !== {1'b1, 32'd3}) begin n_bad++; $display("FAIL stall_count got fin=%b transfers=%0d want 1 3", fin, k); end
        out_ready = 1'b0;
    endtask

    task automatic test_same_cycle;
        logic [53:0] a, b;
        a = ruler(0, 1, 4, 10, 12, 17);
        b = ruler(0, 2, 7, 13, 16, 17);
        do_reset;
        send(a);
        search_done = 1'b1;
        send(b);
        search_done = 1'b0;
        out_ready = 1'b1;
        n_cmp++; if ({num_results, out_valid, out_last, out_marks} !== {6'd2, 2'b10, a}) begin n_bad++; $display("FAIL same_rd0 got num=%0d %b %h", num_results, {out_valid, out_last}, out_marks); end
        step;
        n_cmp++; if ({out_valid, out_last, out_marks} !== {2'b11, b}) begin n_bad++; $display("FAIL same_rd1 got %b %h want 11 %h", {out_valid, out_last}, out_marks, b); end
        out_ready = 1'b0;
    endtask

    task automatic test_reset_drain;
        do_reset;
        send(ruler(0, 1, 4, 10, 12, 17));
        send(ruler(0, 1, 4, 10, 15, 17));
        send(ruler(0, 2, 7, 13, 16, 17));
        out_ready = 1'b1;
        pulse_done;
        step;
        n_cmp++; if ({b_out_valid, b_out_last} !== 2'b11) begin n_bad++; $display("FAIL rstd_mid got %b want 11", {b_out_valid, b_out_last}); end
        reset = 1'b1;
        step;
        reset = 1'b0;
        out_ready = 1'b0;
        n_cmp++; if ({b_num_results, b_out_valid, b_cand_ready, b_overflow, b_done} !== {6'd0, 4'b0100}) begin n_bad++; $display("FAIL rstd_small got num=%0d v=%b rdy=%b ovf=%b done=%b", b_num_results, b_out_valid, b_cand_ready, b_overflow, b_done); end
        n_cmp++; if ({num_results, out_valid, cand_ready, best_len, out_marks} !== {6'd0, 2'b01, 9'h1ff, 54'd0}) begin n_bad++; $display("FAIL rstd_big got num=%0d v=%b rdy=%b best=%h marks=%h", num_results, out_valid, cand_ready, best_len, out_marks); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_shorter;
        test_overflow;
        test_overflow_clear;
        test_empty;
        test_stall;
        test_same_cycle;
        test_reset_drain;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
